dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory slave serving the memory stage. The memory stage issues load/store requests over a valid/ready handshake, and the results flow on to writeback.
- Holds the word-addressed data array internally and inserts a configurable number of wait states per access.
- Returns exactly one response pulse per accepted request: read data or write acknowledge, with an error flag.
- Out-of-range addresses are flagged with an error instead of aliasing onto valid locations.

Parameters:
- ADDR_W, 12: width of the word address.
- DATA_W, 32: data width. Must be 32; byte-enable logic is 4 lanes.
- DEPTH, 1024: number of implemented words. Must be <= 2^ADDR_W.
- WAIT_CYC, 2: wait states per access, range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  memory stage presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_be  in  4  byte enables for stores, bit i covers byte i. Ignored for loads.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  load data. 0 for stores and errors.
- resp_err  out  1  address >= DEPTH. Qualified by resp_valid.

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0; wait counter=0. The data array is not reset and its contents are undefined.
- req_ready is registered. It goes to 1 on the first rising edge after rst_n deasserts.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid&&req_ready, capture we/addr/wdata/be and drop req_ready.
  - Next state is WAIT with counter=WAIT_CYC-1, or RESP directly if WAIT_CYC==0.
- WAIT:
  - Counter decrements each edge.
  - At counter==0 the array access is performed and the state moves to RESP.
- Array access on the WAIT->RESP edge (or the IDLE->RESP edge when WAIT_CYC==0):
  - Load: resp_rdata <= mem[addr].
  - Store: mem[addr] byte lanes with be=1 are updated; resp_rdata <= 0.
  - If addr >= DEPTH: no array read or write; resp_err <= 1; resp_rdata <= 0.
- RESP:
  - resp_valid=1 for exactly one cycle; the state then returns to IDLE.
  - req_ready returns to 1 on that same edge.
  - On the following edge resp_valid, resp_err and resp_rdata clear to 0.
- Latency: request accepted at edge N → resp_valid high in the cycle after edge N+1+WAIT_CYC.
- Throughput: one access per WAIT_CYC+2 cycles. No pipelining; requests are never overlapped.
- No response backpressure: the memory stage must sample resp_valid in the cycle it is high.
- Captured request fields are stable from accept to response. Changes on req_* inputs while req_ready=0 are ignored.
- Store with be=4'b0000 is a legal no-op and still produces a response.
- Reset mid-operation (WAIT or RESP) aborts the access:
  - No response pulse.
  - A store not yet committed (still in WAIT) leaves memory unchanged.
- Simultaneous req_valid and rst_n assertion: reset wins and the request is dropped.

Optional Feature:
- Macro: DMEM_ACCESS_CNT_EN.
- Defined:
  - Adds output ports rd_cnt[15:0] and wr_cnt[15:0], both reset to 0.
  - Each increments on the RESP-entry edge of a non-error load or store respectively.
  - Each saturates at 16'hFFFF.
  - Error accesses are not counted.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Store 0xDEADBEEF to addr 0x010 with be=4'hF, then load 0x010 → resp_valid pulses once per access, 3 cycles after the accept edge (WAIT_CYC=2); load resp_rdata=0xDEADBEEF, resp_err=0.
- Store 0x11223344 to 0x010 with be=4'b0101 over 0xDEADBEEF, then load → 0xDE22BE44.
- Load 0x400 and store 0x5A5A5A5A to 0x7FF (DEPTH=1024) → resp_err=1, resp_rdata=0 for both; a load of 0x010 still returns 0xDE22BE44.
- Hold req_valid=1 for three back-to-back loads → accepts spaced exactly 4 cycles apart; req_ready=0 between accepts; three responses in order.
- Store 0 to 0x020, then store 0xCAFEF00D to 0x020 and assert rst_n=0 during WAIT → no resp_valid; after reset a load of 0x020 returns 0x00000000.
- With DMEM_ACCESS_CNT_EN: 2 good loads, 1 good store, 1 error load → rd_cnt=2, wr_cnt=1; forcing rd_cnt to 0xFFFF then one more load → rd_cnt stays 0xFFFF.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory slave with wait states; optional access counters (DMEM_ACCESS_CNT_EN)
module dmem_responder #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
`ifdef DMEM_ACCESS_CNT_EN
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
`endif
    output logic              resp_err
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DEPTH_U   = DEPTH;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_be;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_resp_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_access;
    logic                w_acc_we;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic [3:0]          w_acc_be;
    logic                w_oor;
    logic [IDX_W-1:0]    w_idx;
    logic                w_mem_wr;

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    assign w_accept = (r_state == S_IDLE) && r_req_ready && req_valid;

    // With zero wait states the access happens on the accept edge itself, so the
    // live request fields are used instead of the not-yet-captured copies.
    assign w_access    = ((r_state == S_WAIT) && (r_cnt == 4'd0)) || ((WAIT_CYC == 0) && w_accept);
    assign w_acc_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_acc_be    = (r_state == S_IDLE) ? req_be    : r_be;
    assign w_oor       = 32'(w_acc_addr) >= DEPTH_U;
    assign w_idx       = w_acc_addr[IDX_W-1:0];
    assign w_mem_wr    = w_access && w_acc_we && !w_oor;

    // Byte-lane store into the array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= 4'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_req_ready  <= 1'b1;
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_be        <= req_be;
                        r_req_ready <= 1'b0;
                        if (WAIT_CYC == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b1;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // Access result overrides the IDLE clear when the access shares the accept edge.
            if (w_access) begin
                r_resp_err   <= w_oor;
                r_resp_rdata <= (w_acc_we || w_oor) ? '0 : r_mem[w_idx];
            end
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;

    // Saturating counts of successful loads and stores, taken on the access edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else if (w_access && !w_oor) begin
            if (w_acc_we) begin
                if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
            end else begin
                if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed-vector bench for dmem_responder
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
`endif

    dmem_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
`ifdef DMEM_ACCESS_CNT_EN
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
`endif
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    logic [31:0] resp_q[$];

    always @(posedge clk) cyc++;
    always @(negedge clk) if (resp_valid) resp_q.push_back(resp_rdata);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        bit ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) check_eq(tag, 32'(ok), 32'd1);
    endtask

    // One full access; returns response data/error and edges from accept to pulse.
    task automatic do_access(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] rd, output logic err,
                             output int lat);
        bit ok = 0;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
        wait_ready("accept_timeout");
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = 12'h3FF; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            if (resp_valid) begin ok = 1; break; end
            lat++;
            @(negedge clk);
        end
        if (!ok) check_eq("resp_timeout", 32'(ok), 32'd1);
        rd  = resp_rdata;
        err = resp_err;
        @(negedge clk);
        check_eq("pulse_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc[3];
    logic [11:0] b2b_addr[3];
    int          base;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        #1 check_eq("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("ready_after_edge", 32'(req_ready), 32'd1);

        // full-word store then load
        do_access(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, err, lat);
        check_eq("st_lat", 32'(lat), 32'd3);
        check_eq("st_rdata", rd, 32'd0);
        check_eq("st_err", 32'(err), 32'd0);
        do_access(1'b0, 12'h010, 32'h0, 4'h0, rd, err, lat);
        check_eq("ld_lat", 32'(lat), 32'd3);
        check_eq("ld_rdata", rd, 32'hDEADBEEF);
        check_eq("ld_err", 32'(err), 32'd0);

        // partial byte-enable store
        do_access(1'b1, 12'h010, 32'h11223344, 4'b0101, rd, err, lat);
        do_access(1'b0, 12'h010, 32'h0, 4'h0, rd, err, lat);
        check_eq("be_merge", rd, 32'hDE22BE44);
        do_access(1'b1, 12'h011, 32'h01234567, 4'hF, rd, err, lat);
        do_access(1'b1, 12'h012, 32'hFFFFFFFF, 4'h0, rd, err, lat);
        check_eq("be0_err", 32'(err), 32'd0);

        // out-of-range accesses
        do_access(1'b0, 12'h400, 32'h0, 4'h0, rd, err, lat);
        check_eq("oor_ld_err", 32'(err), 32'd1);
        check_eq("oor_ld_rdata", rd, 32'd0);
        do_access(1'b1, 12'h7FF, 32'h5A5A5A5A, 4'hF, rd, err, lat);
        check_eq("oor_st_err", 32'(err), 32'd1);
        check_eq("oor_st_rdata", rd, 32'd0);
        do_access(1'b0, 12'h010, 32'h0, 4'h0, rd, err, lat);
        check_eq("no_alias", rd, 32'hDE22BE44);

        // back-to-back loads with req_valid held high
        b2b_addr[0] = 12'h010; b2b_addr[1] = 12'h011; b2b_addr[2] = 12'h010;
        resp_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0;
        for (int i = 0; i < 3; i++) begin
            req_addr = b2b_addr[i];
            wait_ready("b2b_timeout");
            acc[i] = cyc;
            @(posedge clk);
            @(negedge clk);
            check_eq("b2b_ready_low", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("b2b_gap1", 32'(acc[1] - acc[0]), 32'd4);
        check_eq("b2b_gap2", 32'(acc[2] - acc[1]), 32'd4);
        check_eq("b2b_nresp", 32'(resp_q.size()), 32'd3);
        if (resp_q.size() == 3) begin
            check_eq("b2b_r0", resp_q[0], 32'hDE22BE44);
            check_eq("b2b_r1", resp_q[1], 32'h01234567);
            check_eq("b2b_r2", resp_q[2], 32'hDE22BE44);
        end

        // reset during WAIT aborts an uncommitted store
        do_access(1'b1, 12'h020, 32'h0, 4'hF, rd, err, lat);
        @(negedge clk);
        req_we = 1'b1; req_addr = 12'h020; req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
        wait_ready("abort_timeout");
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        base = resp_q.size();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("abort_no_resp", 32'(resp_q.size() - base), 32'd0);
`ifdef DMEM_ACCESS_CNT_EN
        check_eq("cnt_rst_rd", 32'(rd_cnt), 32'd0);
        check_eq("cnt_rst_wr", 32'(wr_cnt), 32'd0);
`endif
        do_access(1'b0, 12'h020, 32'h0, 4'h0, rd, err, lat);
        check_eq("abort_mem", rd, 32'd0);

`ifdef DMEM_ACCESS_CNT_EN
        do_access(1'b0, 12'h010, 32'h0, 4'h0, rd, err, lat);
        do_access(1'b1, 12'h030, 32'h1, 4'hF, rd, err, lat);
        do_access(1'b0, 12'h400, 32'h0, 4'h0, rd, err, lat);
        check_eq("cnt_rd", 32'(rd_cnt), 32'd2);
        check_eq("cnt_wr", 32'(wr_cnt), 32'd1);
        @(negedge clk);
        force dut.r_rd_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_rd_cnt;
        do_access(1'b0, 12'h010, 32'h0, 4'h0, rd, err, lat);
        check_eq("cnt_sat", 32'(rd_cnt), 32'h0000FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
